data_memory_line: RTL

Line-granular backing data memory sitting directly downstream of the data cache. It consumes the cache's memory-side request (enable, write, address, 256-bit line). It answers with a single-cycle ack after a fixed access latency, and returns read data on the same cycle. It models off-chip DRAM timing so the cache miss/stall path of the pipelined CPU is exercised.

---
 rtl/data_memory_line.sv | 112 +++++++++++
 1 files changed

// File: rtl/data_memory_line.sv
// Line-granular backing memory behind the data cache. Each request is
// acknowledged with a single-cycle pulse a fixed LATENCY cycles after it is
// accepted, which models off-chip DRAM timing for the cache miss/stall path.
// Optional feature macro: MEM_BOUNDS_CHECK_EN. When it is defined, a request
// with any nonzero address bit above the line index is out of range. An
// out-of-range read returns zero and an out-of-range write is dropped.
module data_memory_line #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned LATENCY   = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_enable_i,
    input  logic                 mem_write_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [LINE_BITS-1:0] mem_data_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_ack_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 wr_q;
    logic                 in_range_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] mem [DEPTH];

    logic                 in_range_c;
    logic                 commit_c;
    logic                 unused_c;

`ifdef MEM_BOUNDS_CHECK_EN
    assign in_range_c = (mem_addr_i[31:5+IDX_W] == '0);
    assign unused_c   = ^mem_addr_i[4:0];
`else
    // Upper address bits are ignored, so the index wraps modulo DEPTH.
    assign in_range_c = 1'b1;
    assign unused_c   = ^{mem_addr_i[4:0], mem_addr_i[31:5+IDX_W]};
`endif

    // The access commits on the last BUSY edge, when the counter has reached zero.
    assign commit_c = (state_q == BUSY) && (cnt_q == '0);

    // Request sequencing: capture on accept, count down the latency, then pulse ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            in_range_q <= 1'b0;
            wdata_q    <= '0;
            mem_data_o <= '0;
            mem_ack_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            mem_ack_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_enable_i) begin
                        idx_q      <= mem_addr_i[5 +: IDX_W];
                        wr_q       <= mem_write_i;
                        in_range_q <= in_range_c;
                        wdata_q    <= mem_data_i;
                        cnt_q      <= CNT_W'(LATENCY - 1);
                        busy_o     <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) begin
                            mem_data_o <= in_range_q ? mem[idx_q] : '0;
                        end
                        mem_ack_o <= 1'b1;
                        state_q   <= ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ACK: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Line storage is never cleared. Reset forces IDLE, so an in-flight write is lost.
    always_ff @(posedge clk_i) begin
        if (commit_c && wr_q && in_range_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
